// File: rtl/regfile_pkg.sv
// Shared widths, types and constants for the multi-port register file with busy scoreboard.
package regfile_pkg;

   localparam int DEF_DATA_WIDTH    = 32;
   localparam int DEF_ADDRESS_WIDTH = 5;
   localparam int DEF_NUM_REGS      = 2 ** DEF_ADDRESS_WIDTH;

   typedef logic [DEF_ADDRESS_WIDTH-1:0] reg_addr_t;
   typedef logic [DEF_DATA_WIDTH-1:0]    reg_data_t;
   typedef logic [DEF_NUM_REGS-1:0]      busy_vec_t;

   localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with set-over-clear priority and a registered popcount of pending registers.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int NUM_REGS      = 2 ** ADDRESS_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REGS-1:0]      clr_vec,
   input  logic                     set_en,
   input  logic [ADDRESS_WIDTH-1:0] set_dest,
   output logic [NUM_REGS-1:0]      busy,
   output logic [ADDRESS_WIDTH:0]   busy_cnt
);

   localparam int CW = ADDRESS_WIDTH + 1;

   logic [NUM_REGS-1:0] set_vec;
   logic [NUM_REGS-1:0] busy_next;
   logic [CW-1:0]       cnt_next;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      set_vec = '0;
      if (set_en && (set_dest != '0))
         set_vec[set_dest] = 1'b1;
      // A producer issued this cycle outranks the writeback of the previous one.
      busy_next = (busy & ~clr_vec) | set_vec;
      cnt_next  = '0;
      for (int i = 0; i < NUM_REGS; i++)
         cnt_next = cnt_next + CW'(busy_next[i]);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_next;
         busy_cnt <= cnt_next;
      end
   end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with RAW busy scoreboard; x0 reads zero and is never busy.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp_sb
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int NUM_REGS      = 2 ** ADDRESS_WIDTH,
   parameter int NUM_RD_PORTS  = 2,
   parameter int NUM_WR_PORTS  = 2
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [NUM_WR_PORTS-1:0]                    rg_wrt_en,
   input  logic [NUM_WR_PORTS-1:0][ADDRESS_WIDTH-1:0] rg_wrt_dest,
   input  logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0]    rg_wrt_data,
   input  logic [NUM_RD_PORTS-1:0][ADDRESS_WIDTH-1:0] rg_rd_addr,
   output logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0]    rg_rd_data,
   output logic [NUM_RD_PORTS-1:0]                    rg_rd_busy,
   input  logic                                       sb_set_en,
   input  logic [ADDRESS_WIDTH-1:0]                   sb_set_dest,
   output logic [ADDRESS_WIDTH:0]                     sb_busy_cnt
);

   logic [DATA_WIDTH-1:0] regs   [NUM_REGS];
   logic [DATA_WIDTH-1:0] wr_val [NUM_REGS];
   logic [NUM_REGS-1:0]   wr_hit;
   logic [NUM_REGS-1:0]   busy;

   // Per-register write select; scanning ports upward lets the highest enabled port win.
   always_comb begin
      wr_hit = '0;
      for (int i = 0; i < NUM_REGS; i++)
         wr_val[i] = '0;
      for (int i = 1; i < NUM_REGS; i++)
         for (int p = 0; p < NUM_WR_PORTS; p++)
            if (rg_wrt_en[p] && (rg_wrt_dest[p] == ADDRESS_WIDTH'(i))) begin
               wr_hit[i] = 1'b1;
               wr_val[i] = rg_wrt_data[p];
            end
   end

   // NOTE: the array is built from flops and must come out of reset as zero, so it is reset explicitly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else begin
         for (int i = 1; i < NUM_REGS; i++)
            if (wr_hit[i])
               regs[i] <= wr_val[i];
      end
   end

   regfile_scoreboard #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .NUM_REGS      (NUM_REGS)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .clr_vec  (wr_hit),
      .set_en   (sb_set_en),
      .set_dest (sb_set_dest),
      .busy     (busy),
      .busy_cnt (sb_busy_cnt)
   );

   // regs[0] and busy[0] are never written, so address 0 reads as zero and not busy.
   always_comb begin
      for (int r = 0; r < NUM_RD_PORTS; r++) begin
         rg_rd_data[r] = regs[rg_rd_addr[r]];
         rg_rd_busy[r] = busy[rg_rd_addr[r]];
`ifdef REGFILE_BYPASS_EN
         for (int p = 0; p < NUM_WR_PORTS; p++)
            if (rg_wrt_en[p] && (rg_wrt_dest[p] != '0) && (rg_wrt_dest[p] == rg_rd_addr[r])) begin
               rg_rd_data[r] = rg_wrt_data[p];
               rg_rd_busy[r] = sb_set_en && (sb_set_dest == rg_rd_addr[r]);
            end
`endif
      end
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: directed vectors then a randomised phase against a reference model.
module tb_regfile_mp_sb;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 32;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic                   clk;
   logic                   rst;
   logic [1:0]             rg_wrt_en;
   logic [1:0][AW-1:0]     rg_wrt_dest;
   logic [1:0][DW-1:0]     rg_wrt_data;
   logic [1:0][AW-1:0]     rg_rd_addr;
   logic [1:0][DW-1:0]     rg_rd_data;
   logic [1:0]             rg_rd_busy;
   logic                   sb_set_en;
   logic [AW-1:0]          sb_set_dest;
   logic [AW:0]            sb_busy_cnt;

   regfile_mp_sb #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .NUM_REGS      (NR),
      .NUM_RD_PORTS  (2),
      .NUM_WR_PORTS  (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rg_wrt_en   (rg_wrt_en),
      .rg_wrt_dest (rg_wrt_dest),
      .rg_wrt_data (rg_wrt_data),
      .rg_rd_addr  (rg_rd_addr),
      .rg_rd_data  (rg_rd_data),
      .rg_rd_busy  (rg_rd_busy),
      .sb_set_en   (sb_set_en),
      .sb_set_dest (sb_set_dest),
      .sb_busy_cnt (sb_busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string         name;
      logic [DW-1:0] d0;
      logic          b0;
      logic [DW-1:0] d1;
      logic          b1;
      logic [AW:0]   cnt;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Monitor: outputs are settled mid-cycle, so compare on the falling edge whenever a response is queued.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({e.name, ".d0"},  rg_rd_data[0],           e.d0);
         check({e.name, ".b0"},  DW'(rg_rd_busy[0]),      DW'(e.b0));
         check({e.name, ".d1"},  rg_rd_data[1],           e.d1);
         check({e.name, ".b1"},  DW'(rg_rd_busy[1]),      DW'(e.b1));
         check({e.name, ".cnt"}, DW'(sb_busy_cnt),        DW'(e.cnt));
      end
   end

   task automatic drive(input logic [1:0] we, input logic [AW-1:0] wd0, input logic [AW-1:0] wd1,
                        input logic [DW-1:0] wv0, input logic [DW-1:0] wv1, input logic se,
                        input logic [AW-1:0] sd, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
      rg_wrt_en      = we;
      rg_wrt_dest[0] = wd0;
      rg_wrt_dest[1] = wd1;
      rg_wrt_data[0] = wv0;
      rg_wrt_data[1] = wv1;
      sb_set_en      = se;
      sb_set_dest    = sd;
      rg_rd_addr[0]  = ra0;
      rg_rd_addr[1]  = ra1;
   endtask

   // One directed cycle: drive, queue the hand-computed response, advance past the edge.
   task automatic vec(input string name, input logic [1:0] we, input logic [AW-1:0] wd0,
                      input logic [AW-1:0] wd1, input logic [DW-1:0] wv0, input logic [DW-1:0] wv1,
                      input logic se, input logic [AW-1:0] sd, input logic [AW-1:0] ra0,
                      input logic [AW-1:0] ra1, input logic [DW-1:0] ed0, input logic eb0,
                      input logic [DW-1:0] ed1, input logic eb1, input logic [AW:0] ecnt);
      drive(we, wd0, wd1, wv0, wv1, se, sd, ra0, ra1);
      exp_q.push_back('{name, ed0, eb0, ed1, eb1, ecnt});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   logic [DW-1:0] mem_m  [NR];
   bit            busy_m [NR];

   function automatic void model_read(input logic [AW-1:0] a, input logic [1:0] we,
                                      input logic [AW-1:0] wd0, input logic [AW-1:0] wd1,
                                      input logic [DW-1:0] wv0, input logic [DW-1:0] wv1,
                                      input logic se, input logic [AW-1:0] sd,
                                      output logic [DW-1:0] d, output logic b);
      d = (a == 0) ? '0 : mem_m[a];
      b = (a == 0) ? 1'b0 : busy_m[a];
      if (BYPASS) begin
         if (we[0] && wd0 != 0 && wd0 == a) begin d = wv0; b = se && (sd == a); end
         if (we[1] && wd1 != 0 && wd1 == a) begin d = wv1; b = se && (sd == a); end
      end
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR - 1));
      return AW'($urandom_range(0, 7));
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: time got %0t want below 500000", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      do_reset();

      // Reset: populate x5, then assert reset between edges and expect immediate clearing.
      vec("t1_wr", 2'b01, 5, 0, 32'hDEAD, 0, 1'b1, 5, 5, 0,
          BYPASS ? 32'hDEAD : 32'h0, BYPASS ? 1'b1 : 1'b0, 0, 1'b0, 0);
      vec("t1_pre", 2'b00, 0, 0, 0, 0, 1'b0, 0, 5, 0, 32'hDEAD, 1'b1, 0, 1'b0, 1);
      drive(2'b01, 7, 0, 32'h1234, 0, 1'b1, 6, 5, 6);
      #1;
      rst = 1'b1;
      exp_q.push_back('{"t1_async_rst", 32'h0, 1'b0, 32'h0, 1'b0, 6'd0});
      @(posedge clk);
      #1;
      rst = 1'b0;
      vec("t1_discard", 2'b00, 0, 0, 0, 0, 1'b0, 0, 7, 6, 0, 1'b0, 0, 1'b0, 0);

      // Write-port priority on the same destination.
      vec("t2_wr", 2'b11, 7, 7, 32'h1111, 32'h2222, 1'b0, 0, 7, 7,
          BYPASS ? 32'h2222 : 32'h0, 1'b0, BYPASS ? 32'h2222 : 32'h0, 1'b0, 0);
      vec("t2_rd", 2'b00, 0, 0, 0, 0, 1'b0, 0, 7, 5, 32'h2222, 1'b0, 0, 1'b0, 0);

      // x0 ignores writes and scoreboard sets.
      vec("t3_wr", 2'b01, 0, 0, 32'hFFFF_FFFF, 0, 1'b1, 0, 0, 0, 0, 1'b0, 0, 1'b0, 0);
      vec("t3_rd", 2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 7, 0, 1'b0, 32'h2222, 1'b0, 0);

      // Scoreboard: set wins over clear, no nesting, clear on writeback.
      vec("t4_set3", 2'b00, 0, 0, 0, 0, 1'b1, 3, 3, 4, 0, 1'b0, 0, 1'b0, 0);
      vec("t4_set4", 2'b00, 0, 0, 0, 0, 1'b1, 4, 3, 4, 0, 1'b1, 0, 1'b0, 1);
      vec("t4_wrset3", 2'b01, 3, 0, 32'h3333, 0, 1'b1, 3, 3, 4,
          BYPASS ? 32'h3333 : 32'h0, 1'b1, 0, 1'b1, 2);
      vec("t4_hold", 2'b00, 0, 0, 0, 0, 1'b0, 0, 3, 4, 32'h3333, 1'b1, 0, 1'b1, 2);
      vec("t4_wr3", 2'b10, 0, 3, 0, 32'h4444, 1'b0, 0, 3, 4,
          BYPASS ? 32'h4444 : 32'h3333, BYPASS ? 1'b0 : 1'b1, 0, 1'b1, 2);
      vec("t4_clr3", 2'b00, 0, 0, 0, 0, 1'b1, 4, 3, 4, 32'h4444, 1'b0, 0, 1'b1, 1);
      vec("t4_reset4", 2'b00, 0, 0, 0, 0, 1'b0, 0, 3, 4, 32'h4444, 1'b0, 0, 1'b1, 1);
      vec("t4_wr4", 2'b01, 4, 0, 32'h5555, 0, 1'b0, 0, 4, 3,
          BYPASS ? 32'h5555 : 32'h0, BYPASS ? 1'b0 : 1'b1, 32'h4444, 1'b0, 1);
      vec("t4_clr4", 2'b00, 0, 0, 0, 0, 1'b0, 0, 4, 3, 32'h5555, 1'b0, 32'h4444, 1'b0, 0);

      // Forwarding behaviour (or its absence) on a busy register.
      vec("t5_set9", 2'b00, 0, 0, 0, 0, 1'b1, 9, 9, 0, 0, 1'b0, 0, 1'b0, 0);
      vec("t5_wr9", 2'b01, 9, 0, 32'hABCD, 0, 1'b0, 0, 9, 0,
          BYPASS ? 32'hABCD : 32'h0, BYPASS ? 1'b0 : 1'b1, 0, 1'b0, 1);
      vec("t5_rd9", 2'b00, 0, 0, 0, 0, 1'b0, 0, 9, 0, 32'hABCD, 1'b0, 0, 1'b0, 0);

      // Randomised phase against the reference model.
      do_reset();
      for (int i = 0; i < NR; i++) begin
         mem_m[i]  = '0;
         busy_m[i] = 1'b0;
      end
      for (int n = 0; n < 3000; n++) begin
         logic [1:0]    we;
         logic [AW-1:0] wd0, wd1, sd, ra0, ra1;
         logic [DW-1:0] wv0, wv1, ed0, ed1;
         logic          se, eb0, eb1;
         logic [AW:0]   ecnt;
         we  = 2'($urandom_range(0, 3));
         wd0 = rand_addr();
         wd1 = rand_addr();
         wv0 = DW'($urandom);
         wv1 = DW'($urandom);
         se  = 1'($urandom_range(0, 1));
         sd  = rand_addr();
         ra0 = rand_addr();
         ra1 = rand_addr();
         drive(we, wd0, wd1, wv0, wv1, se, sd, ra0, ra1);
         model_read(ra0, we, wd0, wd1, wv0, wv1, se, sd, ed0, eb0);
         model_read(ra1, we, wd0, wd1, wv0, wv1, se, sd, ed1, eb1);
         ecnt = '0;
         for (int i = 0; i < NR; i++) ecnt = ecnt + (AW + 1)'(busy_m[i]);
         exp_q.push_back('{"rnd", ed0, eb0, ed1, eb1, ecnt});
         @(posedge clk);
         if (we[0] && wd0 != 0) begin mem_m[wd0] = wv0; busy_m[wd0] = 1'b0; end
         if (we[1] && wd1 != 0) begin mem_m[wd1] = wv1; busy_m[wd1] = 1'b0; end
         if (se && sd != 0) busy_m[sd] = 1'b1;
         #1;
      end

      drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
